// File: rtl/tcb_lite_pkg.sv
// Shared TCB lite types and helpers used by subordinate implementations.
// Request/response structs are macros because their widths follow each instance's parameters.
`ifndef TCB_LITE_PKG_SV
`define TCB_LITE_PKG_SV

`define TCB_LITE_REQ_T(ADR, DAT) struct packed { logic lck; logic ndn; logic wen; logic [(ADR)-1:0] adr; logic [$clog2((DAT)/8)-1:0] siz; logic [(DAT)/8-1:0] byt; logic [(DAT)-1:0] wdt; }
`define TCB_LITE_RSP_T(DAT) struct packed { logic err; logic [(DAT)-1:0] rdt; }

package tcb_lite_pkg;

  function automatic int byt_of(input int dat);
    return dat / 8;
  endfunction

  function automatic int max_of(input int dat);
    return $clog2(dat / 8);
  endfunction

  // Logarithmic size to a byte-lane mask anchored at lane 0.
  function automatic logic [7:0] siz2byt(input logic [2:0] siz);
    logic [7:0] b;
    case (siz)
      3'd0:    b = 8'h01;
      3'd1:    b = 8'h03;
      3'd2:    b = 8'h0f;
      default: b = 8'hff;
    endcase
    return b;
  endfunction

endpackage

`endif

// File: rtl/tcb_lite_rsp_dly.sv
// Response delay line: DLY valid-tagged stages, output holds the last response.
module tcb_lite_rsp_dly #(
  parameter int DLY = 1,
  parameter int W   = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  output logic [W-1:0] out_dat
);

  if (DLY == 0) begin : g_comb
    logic [W-1:0] hold;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst)        hold <= '0;
      else if (in_vld) hold <= in_dat;
    end

    assign out_vld = in_vld;
    assign out_dat = in_vld ? in_dat : hold;
  end else begin : g_pipe
    logic [DLY-1:0] vld_q;
    logic [W-1:0]   dat_q [DLY];

    // Inner stages advance every cycle; only the last stage waits for a valid tag.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        vld_q <= '0;
        for (int i = 0; i < DLY; i++) dat_q[i] <= '0;
      end else begin
        vld_q[0] <= in_vld;
        if (DLY > 1 || in_vld) dat_q[0] <= in_dat;
        for (int i = 1; i < DLY; i++) begin
          vld_q[i] <= vld_q[i-1];
          if (i < DLY - 1 || vld_q[i-1]) dat_q[i] <= dat_q[i-1];
        end
      end
    end

    assign out_vld = vld_q[DLY-1];
    assign out_dat = dat_q[DLY-1];
  end

endmodule

// File: rtl/tcb_lite_sub_mem.sv
// TCB lite subordinate memory: wait-state handshake, byte-lane writes, delayed read response.
module tcb_lite_sub_mem
  import tcb_lite_pkg::*;
#(
  parameter int DLY  = 1,
  parameter int DAT  = 32,
  parameter int ADR  = 32,
  parameter int MOD  = 1,
  parameter int SIZE = 4096,
  parameter int WAIT = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     vld,
  output logic                     rdy,
  input  logic                     lck,
  input  logic                     ndn,
  input  logic                     wen,
  input  logic [ADR-1:0]           adr,
  input  logic [$clog2(DAT/8)-1:0] siz,
  input  logic [DAT/8-1:0]         byt,
  input  logic [DAT-1:0]           wdt,
  output logic [DAT-1:0]           rdt,
  output logic                     err
);

  localparam int BYT = byt_of(DAT);
  localparam int MAX = max_of(DAT);
  localparam int AW  = $clog2(SIZE);
  localparam int DEP = SIZE / BYT;

  typedef `TCB_LITE_RSP_T(DAT) rsp_t;

  if (DAT != 32 && DAT != 64) begin : g_bad_dat
    $error("tcb_lite_sub_mem: DAT must be 32 or 64");
  end
  if (DLY < 0 || DLY > 4) begin : g_bad_dly
    $error("tcb_lite_sub_mem: DLY must be within 0..4");
  end
  if (WAIT < 0 || WAIT > 15) begin : g_bad_wait
    $error("tcb_lite_sub_mem: WAIT must be within 0..15");
  end
  if (SIZE < BYT || (SIZE & (SIZE - 1)) != 0 || (SIZE % BYT) != 0) begin : g_bad_size
    $error("tcb_lite_sub_mem: SIZE must be a power of two and a multiple of DAT/8");
  end

  logic [3:0]        cnt;
  logic              trn;
  logic [MAX-1:0]    off;
  logic [AW-MAX-1:0] idx;
  logic              err_rng, err_aln, err_c;
  logic [BYT-1:0]    siz_lns, lns;
  logic [DAT-1:0]    siz_msk, wdat, rword, rdat;
  logic [DAT-1:0]    mem [DEP];
  rsp_t              rsp_c, rsp_q;
  logic              rsp_vld;

  // Counting stops at WAIT, which is what raises rdy; with WAIT=0 rdy never drops.
  assign rdy = (cnt == 4'(WAIT));
  assign trn = vld & rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     cnt <= '0;
    else if (trn) cnt <= '0;
    else if (vld) cnt <= cnt + 4'd1;
  end

  assign off     = adr[MAX-1:0];
  assign idx     = adr[AW-1:MAX];
  assign err_rng = (adr >= ADR'(SIZE));
  assign err_aln = (MOD == 0) ? |(off & MAX'((1 << siz) - 1)) : 1'b0;
  assign err_c   = err_rng | err_aln;

  assign siz_lns = BYT'(siz2byt(3'(siz)));
  for (genvar i = 0; i < BYT; i++) begin : g_msk
    assign siz_msk[8*i +: 8] = {8{siz_lns[i]}};
  end

  // Logarithmic mode carries data LSB-aligned, so shift it onto/off the addressed lanes.
  assign lns   = (MOD == 1) ? byt : (siz_lns << off);
  assign wdat  = (MOD == 1) ? wdt : (wdt << {off, 3'b000});
  assign rword = mem[idx];
  assign rdat  = (MOD == 1) ? rword : ((rword >> {off, 3'b000}) & siz_msk);

  always_ff @(posedge clk) begin
    if (trn && wen && !err_c) begin
      for (int i = 0; i < BYT; i++) begin
        if (lns[i]) mem[idx][8*i +: 8] <= wdat[8*i +: 8];
      end
    end
  end

  always_comb begin
    rsp_c.err = err_c;
    rsp_c.rdt = (wen || err_c) ? '0 : rdat;
  end

  tcb_lite_rsp_dly #(
    .DLY (DLY),
    .W   ($bits(rsp_t))
  ) u_rsp_dly (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (trn),
    .in_dat  (rsp_c),
    .out_vld (rsp_vld),
    .out_dat (rsp_q)
  );

  assign rdt = rsp_q.rdt;
  assign err = rsp_q.err;

  logic unused_ok;
  assign unused_ok = &{1'b0, lck, ndn, byt, siz, rsp_vld};

endmodule

// File: doc/tcb_lite_sub_mem.md
Name: tcb_lite_sub_mem

Overview:
- TCB lite subordinate (responder): a byte-addressable memory that terminates a manager's request stream.
- Generates `rdy` with configurable wait states, performs writes on transfer, and returns `rdt`/`err` exactly DLY cycles after each transfer.
- Serves as an on-chip scratchpad/boot RAM and as the reference responder for TCB manager benches.
- A thin wrapper connects it to a `tcb_lite_if.sub` modport; the ports below are flattened.

Parameters:
- DLY, 1, response latency in cycles after transfer; legal range 0..4.
- DAT, 32, data width; 32 or 64 only.
- ADR, 32, address width.
- MOD, 1, bus mode: 0 = logarithmic size (`siz`), 1 = byte enable (`byt`).
- SIZE, 4096, memory size in bytes; power of two, multiple of DAT/8.
- WAIT, 0, wait states inserted before `rdy`; legal range 0..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- vld  in  1  request valid
- rdy  out  1  request ready
- lck  in  1  arbitration lock; ignored
- ndn  in  1  endianness; ignored, storage is little-endian
- wen  in  1  write enable (1 = write)
- adr  in  ADR  byte address
- siz  in  $clog2(DAT/8)  logarithmic transfer size (MOD=0)
- byt  in  DAT/8  byte enables (MOD=1)
- wdt  in  DAT  write data
- rdt  out  DAT  read data
- err  out  1  bus error

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is asynchronous, active-low.
- Reset values:
  - `rdy`: 0 while `rst` is low when WAIT>0; for WAIT=0, `rdy`=1 (combinational constant).
  - `rdt`=0, `err`=0.
  - Wait counter and delay pipeline are cleared.
  - Memory contents are not reset.
- Handshake and wait states:
  - transfer `trn` = `vld` & `rdy`.
  - Wait counter `cnt` (4 bit): while `vld` & ~`rdy`, `cnt` increments.
  - `rdy` = (`cnt` == WAIT).
  - On `trn`, `cnt` returns to 0.
  - If `vld` drops without a transfer, `cnt` holds; the manager must not retract, and the bench asserts this.
  - Back-to-back requests each incur WAIT stall cycles.
- Decode, evaluated on the `trn` cycle:
  - `off` = `adr[MAX-1:0]`, where MAX = $clog2(DAT/8).
  - `idx` = `adr[$clog2(SIZE)-1:MAX]`.
  - Range error if `adr` >= SIZE.
  - Alignment error, MOD=0 only: `adr` mod 2^`siz` != 0.
  - `err` = range error | alignment error.
- Byte lanes:
  - MOD=1: lanes = `byt`; `wdt`/`rdt` are lane-aligned.
  - MOD=0: lanes = `siz2byt(siz)` << `off`.
  - MOD=0 write data is LSB-aligned and is shifted left by 8*`off` before storage.
  - MOD=0 read data is shifted right by 8*`off`; bytes beyond 2^`siz` are zero.
- Write:
  - Enabled lanes of `mem[idx]` are updated at the `trn` clock edge when `wen`=1 and `err`=0.
  - An errored write leaves memory unchanged.
- Read:
  - The word is sampled at the `trn` edge (DLY>=1) or combinationally (DLY=0).
  - Write transfers return `rdt`=0.
  - An errored access returns `rdt`=0.
- Response timing:
  - DLY=0: `rdt`/`err` are valid in the same cycle as `trn`.
  - DLY=N>=1: valid in cycle `trn`+N, carried through an N-stage pipeline tagged with a valid bit.
  - Between responses, `rdt`/`err` hold their last value (hold-last-response semantics).
  - Pipeline stages advance every cycle, so in-order back-to-back responses are guaranteed.
- Ordering: a read issued in the cycle after a write transfer to the same word returns the new data. At most one transfer per cycle, so there are no same-cycle collisions.
- Reset mid-operation: in-flight responses are discarded; after reset is released, `rdt`/`err` stay 0 until the next response.
- Elaboration: illegal DAT, DLY, WAIT or SIZE values must fail elaboration with `$error`.

Decomposition:
- Package `tcb_lite_pkg`:
  - `siz2byt` function.
  - `req_t`/`rsp_t` structs, parameterised via a macro or type parameters.
  - Constants MAX and BYT derivation.
- Sub-module `tcb_lite_rsp_dly`: N-stage valid-tagged response pipeline with hold-last output. It is reused by other subordinates.

Test Plan:
- Reset: with WAIT=2, hold `rst` low mid-burst, then release -> `rdt`=0, `err`=0, `rdy`=0; the pending response is never emitted.
- Full-word access (MOD=1, DLY=1): write `adr`=0x10, `wdt`=0xDEADBEEF, `byt`=0xF, then read 0x10 -> `rdt`=0xDEADBEEF and `err`=0 exactly 1 cycle after the read `trn`.
- Partial byte write (MOD=1): write 0x10 with `byt`=0x2, `wdt`=0x0000AA00 -> readback 0xDEADAAEF; a read the cycle right after the write also returns 0xDEADAAEF.
- Logarithmic mode (MOD=0):
  - `siz`=0, `adr`=0x13, `wdt`=0x55 -> word becomes 0x55ADAAEF.
  - Read `siz`=1 at 0x12 -> `rdt`=0x000055AD.
- Errors:
  - MOD=0 `siz`=2 at `adr` 0x12 -> `err`=1, `rdt`=0, memory unchanged.
  - `adr`=0x1000 with SIZE=4096 -> `err`=1, `rdt`=0.
- Wait states and pipelining (WAIT=2, DLY=2): three back-to-back reads with `vld` held -> `rdy` high every third cycle; each response arrives exactly 2 cycles after its `trn`, in order; `rdt` holds between responses.
